// File: rtl/inv_mix_columns_sched_pkg.sv
// Shared types, constants and GF(2^8) helpers for the InvMixColumns scheduler.
// The field polynomial is x^8 + x^4 + x^3 + x + 1 (0x11B).
package inv_mix_columns_sched_pkg;

  localparam int COL_W    = 32;
  localparam int COL_LAT  = 1;
  localparam int NUM_COLS = 4;
  localparam int BLK_W    = COL_W * NUM_COLS;

  localparam logic [7:0] COEF_E = 8'h0E;
  localparam logic [7:0] COEF_B = 8'h0B;
  localparam logic [7:0] COEF_D = 8'h0D;
  localparam logic [7:0] COEF_9 = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient this folds to a small XOR net.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] cc;
    acc = 8'h00;
    p   = a;
    cc  = c;
    for (int i = 0; i < 8; i++) begin
      if (cc[0]) begin
        acc = acc ^ p;
      end
      p  = xtime(p);
      cc = cc >> 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// One-column InvMixColumns unit: 16 registered coefficient products, XOR-combined
// after the register, giving exactly one cycle of latency.
module inv_mix_single_column
  import inv_mix_columns_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  // prod_q[r][c] holds byte r times coefficient c, c ordered 0E, 0B, 0D, 09.
  logic [3:0][3:0][7:0] prod_q;
  logic [3:0][7:0]      byte_s;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign byte_s[r] = col_i[COL_W-1-8*r -: 8];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        prod_q[r] <= '0;
      end else begin
        prod_q[r][0] <= gf_mul(byte_s[r], COEF_E);
        prod_q[r][1] <= gf_mul(byte_s[r], COEF_B);
        prod_q[r][2] <= gf_mul(byte_s[r], COEF_D);
        prod_q[r][3] <= gf_mul(byte_s[r], COEF_9);
      end
    end

    assign col_o[COL_W-1-8*r -: 8] = prod_q[r][0]
                                   ^ prod_q[(r+1)%4][1]
                                   ^ prod_q[(r+2)%4][2]
                                   ^ prod_q[(r+3)%4][3];
  end

endmodule

// File: rtl/inv_mix_columns_sched.sv
// Scheduler that streams the four columns of a 128-bit state block through a
// single InvMixColumns column unit, with bypass for the final decryption round.
module inv_mix_columns_sched
  import inv_mix_columns_sched_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [0:BLK_W-1] IN,
  input  logic             BYPASS,
  input  logic             ABORT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [0:BLK_W-1] OUT,
  output logic             BUSY
);

  localparam logic [1:0] CAP_OFFSET = 2'(COL_LAT);

  state_e             state_q;
  logic [1:0]         idx_q;
  logic [0:BLK_W-1]   in_q;
  logic [0:BLK_W-1]   out_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;

  logic [1:0]         wr_idx_s;
  logic [COL_W-1:0]   col_in_s;
  logic [COL_W-1:0]   col_res_s;

  assign col_in_s = in_q[{idx_q, 5'd0} +: COL_W];
  // The unit's result lags the issued index by its latency.
  assign wr_idx_s = idx_q - CAP_OFFSET;

  inv_mix_single_column u_col (
    .clk_i (CLK),
    .rst_i (RST),
    .col_i (col_in_s),
    .col_o (col_res_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            in_q       <= IN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            idx_q      <= 2'd0;
            if (BYPASS) begin
              out_q       <= IN;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (ABORT) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            if (idx_q != 2'd0) begin
              out_q[{wr_idx_s, 5'd0} +: COL_W] <= col_res_s;
            end
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (ABORT) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            out_q[{2'd3, 5'd0} +: COL_W] <= col_res_s;
            out_valid_q                  <= 1'b1;
            state_q                      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // ABORT wins over a simultaneous output handshake.
          if (ABORT || OUT_READY) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= 2'd0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT       = out_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_sched.sv
// Scoreboard bench for inv_mix_columns_sched: directed blocks with hand-computed
// results are queued on acceptance and checked by an independent output monitor.
module tb_inv_mix_columns_sched;

  localparam int PERIOD = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_data = '0;
  logic         bypass = 1'b0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:127] out_data;
  logic         busy;

  always #(PERIOD/2) clk = ~clk;

  inv_mix_columns_sched dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN        (in_data),
    .BYPASS    (bypass),
    .ABORT     (abort),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT       (out_data),
    .BUSY      (busy)
  );

  typedef struct {
    logic [0:127] data;
    int           lat;
    time          t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void check128(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Output monitor: latency, data, hold stability and return-to-idle.
  logic         seen = 1'b0;
  logic         exp_idle = 1'b0;
  logic [0:127] held = '0;
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (rst) begin
      seen     = 1'b0;
      exp_idle = 1'b0;
    end else begin
      if (exp_idle) begin
        check1("idle_in_ready", in_ready, 1'b1);
        check1("idle_out_valid", out_valid, 1'b0);
        exp_idle = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = out_data;
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got OUT=%h, expected no output", out_data);
          end else begin
            lat = int'(($time - sb[0].t_acc + PERIOD/2) / PERIOD);
            check_int("latency", lat, sb[0].lat);
          end
        end else begin
          check128("out_stable", out_data, held);
        end
        check1("in_ready_in_hold", in_ready, 1'b0);
        if (abort) begin
          if (sb.size() != 0) void'(sb.pop_front());
          seen     = 1'b0;
          exp_idle = 1'b1;
        end else if (out_ready) begin
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check128("out_data", out_data, e.data);
          end
          seen     = 1'b0;
          exp_idle = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block; when do_push, queue its expected result at the acceptance edge.
  task automatic send(input logic [0:127] d, input logic byp,
                      input logic [0:127] exp_d, input int exp_lat, input logic do_push);
    int guard = 0;
    in_data  = d;
    bypass   = byp;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (do_push) sb.push_back('{data: exp_d, lat: exp_lat, t_acc: $time});
    #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check_int("drain_queue", sb.size(), 0);
    sb.delete();
    tick();
    tick();
  endtask

  initial begin
    logic [0:127] v_same, r_same, v_mix, r_mix, v_byp, v_mix2, r_mix2;
    int guard;
    v_same = 128'h8E4DA1BC_8E4DA1BC_8E4DA1BC_8E4DA1BC;
    r_same = 128'hDB135345_DB135345_DB135345_DB135345;
    v_mix  = 128'h9FDC589D_01010101_C6C6C6C6_8E4DA1BC;
    r_mix  = 128'hF20A225C_01010101_C6C6C6C6_DB135345;
    v_byp  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    v_mix2 = 128'hD5D5D7D6_4D7EBDF8_01010101_9FDC589D;
    r_mix2 = 128'hD4D4D4D5_2D26314C_01010101_F20A225C;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check128("rst_out", out_data, 128'h0);

    send(v_same, 1'b0, r_same, 6, 1'b1);
    check1("busy_in_issue", busy, 1'b1);
    wait_empty();

    send(v_mix, 1'b0, r_mix, 6, 1'b1);
    wait_empty();

    send(v_byp, 1'b1, v_byp, 1, 1'b1);
    wait_empty();

    // Back-pressure: hold the result for 10 cycles.
    out_ready = 1'b0;
    send(v_mix2, 1'b0, r_mix2, 6, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check1("bp_out_valid", out_valid, 1'b1);
    repeat (10) tick();
    out_ready = 1'b1;
    wait_empty();

    // ABORT sampled at T+3 in ISSUE; the next block must still be correct.
    send(v_mix, 1'b0, r_mix, 6, 1'b0);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("abort_in_ready", in_ready, 1'b1);
    check1("abort_busy", busy, 1'b0);
    send(v_same, 1'b0, r_same, 6, 1'b1);
    wait_empty();

    // RST sampled at T+4 discards the block.
    send(v_mix2, 1'b0, r_mix2, 6, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("midrst_out_valid", out_valid, 1'b0);
    check128("midrst_out", out_data, 128'h0);
    check1("midrst_in_ready", in_ready, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    send(v_mix2, 1'b0, r_mix2, 6, 1'b1);
    wait_empty();

    // ABORT in IDLE is ignored: the block accepted alongside it completes.
    abort = 1'b1;
    send(v_mix, 1'b0, r_mix, 6, 1'b1);
    abort = 1'b0;
    wait_empty();

    // ABORT together with OUT_READY in HOLD.
    out_ready = 1'b0;
    send(v_byp, 1'b1, v_byp, 1, 1'b1);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check1("hold_abort_out_valid", out_valid, 1'b0);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_mix_columns_sched.md
INV_MIX_COLUMNS_SCHED -- requirements
Module: inv_mix_columns_sched

Interface
REQ-001 SHALL have port CLK, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port IN_VALID, input, 1 bit: IN carries a state block to process.
REQ-004 SHALL have port IN_READY, output, 1 bit: block accepts IN; transfer occurs on an edge where IN_VALID and IN_READY are both 1.
REQ-005 SHALL have port IN, input, 128 bits [0:127]: state block, column-major; column k = IN[32k:32k+31].
REQ-006 SHALL have port BYPASS, input, 1 bit: sampled with IN; 1 = pass block unchanged (final decryption round).
REQ-007 SHALL have port ABORT, input, 1 bit: synchronous cancel of the block in flight.
REQ-008 SHALL have port OUT_VALID, output, 1 bit: OUT holds a completed block.
REQ-009 SHALL have port OUT_READY, input, 1 bit: consumer takes OUT on an edge where OUT_VALID and OUT_READY are both 1.
REQ-010 SHALL have port OUT, output, 128 bits [0:127]: InvMixColumns result (or bypassed IN), same column layout as IN.
REQ-011 SHALL have port BUSY, output, 1 bit: 1 in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, DRAIN, HOLD.
REQ-013 SHALL assert IN_READY only in IDLE; IN is captured into a 128-bit input register on acceptance.
REQ-014 On acceptance with BYPASS=0, SHALL go to ISSUE with a 2-bit column index of 0.
REQ-015 On acceptance with BYPASS=1, SHALL load OUT from IN and go directly to HOLD (OUT_VALID on the next cycle).
REQ-016 In ISSUE, SHALL drive column[index] to the single column unit on every cycle, then increment the index; after index 3 the FSM SHALL go to DRAIN.
REQ-017 The column unit SHALL have exactly 1 cycle of latency (registered table lookups); the result for column k SHALL be written to OUT[32k:32k+31] one cycle after column k is issued.
REQ-018 DRAIN SHALL last 1 cycle, capture the column 3 result, then go to HOLD.
REQ-019 Latency SHALL be fixed: acceptance edge T; OUT_VALID=1 from T+6 (non-bypass) or T+1 (bypass).
REQ-020 In HOLD, OUT_VALID SHALL be 1 and OUT SHALL be stable until the handshake completes; on OUT_VALID and OUT_READY the FSM SHALL return to IDLE.
REQ-021 Throughput SHALL be at most one block per 7 cycles; no overlap of consecutive blocks.
REQ-022 ABORT=1 in ISSUE, DRAIN or HOLD SHALL force IDLE on the next edge with OUT_VALID=0; OUT contents are then don't-care; ABORT in IDLE SHALL have no effect.
REQ-023 ABORT SHALL take priority over the OUT handshake on the same edge.
REQ-024 Field arithmetic SHALL be GF(2^8) with polynomial 0x11B; output byte r of a column = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3), with indices taken mod 4.

Reset
REQ-025 RST=1 SHALL force IDLE, column index 0, OUT_VALID=0, BUSY=0, IN_READY=1 on the cycle after release, and OUT=0.
REQ-026 RST SHALL override ABORT and all handshakes; RST asserted mid-block SHALL discard that block with no partial OUT_VALID.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the 0E/0B/0D/09 coefficient constants, and the column-width and latency constants (COL_W=32, COL_LAT=1).
REQ-028 SHALL instantiate exactly one sub-module, inv_mix_single_column, which holds the 16 table lookups and XORs for one 32-bit column; the scheduler holds only the FSM, index counter and registers.

Verification
REQ-029 Single block, all four columns = 0x8E4DA1BC, BYPASS=0 -> OUT_VALID at T+6, OUT = 0xDB135345 repeated 4 times.
REQ-030 Mixed columns {0x9FDC589D, 0x01010101, 0xC6C6C6C6, 0x8E4DA1BC} -> OUT = {0xF20A225C, 0x01010101, 0xC6C6C6C6, 0xDB135345}.
REQ-031 BYPASS=1 with IN = 0x00112233...EEFF -> OUT_VALID at T+1, OUT identical to IN.
REQ-032 OUT_READY held 0 for 10 cycles after OUT_VALID -> OUT_VALID and OUT stay constant and IN_READY stays 0; IN_READY=1 the cycle after OUT_READY=1.
REQ-033 ABORT pulsed at T+3, then a new block is accepted -> no OUT_VALID for the first block; the second block's result is correct at its own T+6.
REQ-034 RST asserted at T+4 for 1 cycle -> OUT_VALID=0, OUT=0, IN_READY=1 on the following cycle; a subsequent block completes normally.
